sevseg_scan_ctrl: RTL and testbench
===================================

// Module: sevseg_scan_ctrl
// PURPOSE
//   Multiplexed refresh controller for the 4-digit seven-segment display.
//   Latches a 16-bit value and scans it one digit at a time. Drives the
//   digit select and the nibble into the existing hex-to-segment encoder.
//   Drives the active-low anode enables straight to the pins, with blanking.
//   Value updates are applied only at frame boundaries, so no digit shows a
//   torn frame.
// PARAMETERS
//   REFRESH_DIV  100000  clock cycles per digit slot (>=1); 100 MHz gives a 1 kHz digit rate
//   BLANK_CYC    1000    cycles at the start of each slot with all anodes off (anti-ghost); must be < REFRESH_DIV
// PORTS
//   clk        in   1   system clock; all logic is on the rising edge
//   rst        in   1   synchronous, active-high reset
//   value_in   in   16  hex value to display; digit 0 = value_in[3:0] = rightmost
//   load       in   1   1-cycle strobe that captures value_in into the shadow register
//   lz_en      in   1   1 = suppress leading zeros
//   sw         out  2   current digit index (0..3), feeds the encoder's digit select
//   num        out  4   nibble for the current digit, feeds the encoder
//   an_n       out  4   anode enables, active low: digit0=1110 d1=1101 d2=1011 d3=0111, off=1111
//   frame_done out  1   1-cycle pulse when a new frame starts (the commit cycle)
// BEHAVIOUR
//   Reset values: cnt=0, digit=0, shadow=0, active=0, pending=0,
//     sw=0, num=0, an_n=1111, frame_done=0.
//   Reset mid-operation: state returns to the reset values on the next edge.
//     Any pending load is discarded.
//   Prescaler
//     - cnt counts 0..REFRESH_DIV-1 and wraps.
//     - tick = (cnt==REFRESH_DIV-1).
//     - With REFRESH_DIV=1, tick is 1 every cycle.
//   Digit counter
//     - On tick, digit <= digit+1 mod 4.
//     - A tick with digit==3 is the frame wrap.
//   Load and commit
//     - On load, shadow <= value_in and pending <= 1.
//     - Repeated loads within one frame: the last one wins.
//     - On the wrap edge with pending=1: active <= shadow and pending <= 0.
//     - Load and wrap on the same cycle: the commit uses the old shadow.
//       The new value stays pending for the following frame.
//     - With no pending load, active is held.
//   Frame pulse
//     - frame_done=1 for exactly the one cycle after every wrap edge.
//     - It pulses whether or not a commit happened.
//   Outputs are registered, with 1-cycle latency from digit/active/cnt.
//     - sw <= digit
//     - num <= active[4*digit +: 4]
//     - an_n <= 1111 if the slot is blanked, otherwise the one-hot-low code for digit
//   Slot blanked when either:
//     - (cnt' < BLANK_CYC), where cnt' is the next-state cnt; or
//     - lz_en=1 and digit>0 and active[15:4*digit]==0.
//   Digit 0 is never blanked by leading-zero suppression, so 0x0000 shows "0".
//   num still carries the nibble while a slot is blanked. Only an_n is forced off.
//   Widths
//     - cnt is $clog2(REFRESH_DIV) bits, minimum 1.
//     - digit is 2 bits and wraps naturally.
// STRUCTURE
//   sevseg_pkg: NUM_DIGITS=4, the digit index typedef (2 bits),
//     the anode code table (AN_OFF=4'b1111, AN_CODE[0..3]).
//   Sub-module sevseg_prescaler (REFRESH_DIV): outputs tick and cnt.
//   The top level holds the digit counter, shadow/active/pending and the output registers.
//   The hex-to-segment encoder is instantiated beside this block, not inside it.
// TESTING (REFRESH_DIV=4, BLANK_CYC=1 unless stated)
//   1. Hold rst 3 cycles, then release with value 0.
//      -> an_n=1111 during reset.
//      -> Each 4-cycle slot shows 1111 for 1 cycle, then 1110, 1101, 1011, 0111 in turn.
//      -> sw steps 0,1,2,3 and repeats.
//   2. Pulse load with 16'h1A3F mid-frame.
//      -> The current frame still shows the old value.
//      -> After the wrap, frame_done pulses once, then num = F,3,A,1 for sw 0..3.
//   3. Load 16'h0005 with lz_en=1.
//      -> Digit 0 shows num=5 and an_n=1110; digits 1-3 keep an_n=1111.
//      -> Load 16'h0000: only digit 0 is lit, with num=0.
//      -> Load 16'h0100: digits 0-2 are lit and digit 3 is off.
//   4. Load 16'h1111, then 16'h2222 in the same frame -> only 2222 is ever displayed.
//      Load 16'h3333 on the exact wrap cycle -> 2222 commits now and 3333 on the next wrap.
//   5. Set REFRESH_DIV=1, BLANK_CYC=0 -> sw changes every cycle and frame_done fires every 4 cycles.
//   6. Assert rst for 1 cycle while sw=2 with a load pending.
//      -> Next cycle all outputs are at reset values.
//      -> The pending value is never displayed.

Source files
------------

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types and constants for the seven-segment scan controller
//
// Purpose: digit index type, digit count, anode code table and the
// leading-zero test used by the scan controller.
// Ports: none (package).

package sevseg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_t;

    // Anode enables are active low; all-ones turns every digit off.
    localparam logic [3:0] AN_OFF = 4'b1111;

    // AN_CODE[d] drives only digit d low. Element 0 sits in the low nibble.
    localparam logic [NUM_DIGITS-1:0][3:0] AN_CODE = {
        4'b0111,    // digit 3
        4'b1011,    // digit 2
        4'b1101,    // digit 1
        4'b1110     // digit 0
    };

    // True when digit d and every digit to its left are zero. Digit 0 always
    // returns false, so a value of zero still shows a single "0".
    function automatic logic upper_zero(input logic [15:0] v, input digit_t d);
        case (d)
            2'd1:    upper_zero = (v[15:4] == 12'h000);
            2'd2:    upper_zero = (v[15:8] == 8'h00);
            2'd3:    upper_zero = (v[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sevseg_prescaler.sv
// rtl/sevseg_prescaler.sv - digit-slot prescaler for the scan controller
//
// Purpose: counts 0..REFRESH_DIV-1 and wraps; tick marks the last cycle
// of each digit slot.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   tick  out  1 on the last cycle of a slot (every cycle if REFRESH_DIV=1)
//   cnt   out  current position inside the slot

module sevseg_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - multiplexed refresh controller for a 4-digit display
//
// Purpose: holds a 16-bit value and scans it out one digit per slot, with
// per-slot blanking, optional leading-zero suppression and value updates
// applied only at frame boundaries.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   value_in    in   [15:0] value to display, digit 0 = value_in[3:0]
//   load        in   one-cycle strobe capturing value_in into the shadow
//   lz_en       in   1 = suppress leading zeros
//   sw          out  [1:0] current digit index for the segment encoder
//   num         out  [3:0] nibble for the current digit
//   an_n        out  [3:0] active-low anode enables
//   frame_done  out  one-cycle pulse at the start of each frame

module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [1:0]  sw,
    output logic [3:0]  num,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int          CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [31:0] BLANK_LIM = 32'(BLANK_CYC);

    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    digit_t           digit;
    logic [15:0]      shadow;
    logic [15:0]      active;
    logic             pending;
    logic             wrap;
    logic             blank;

    sevseg_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .cnt  (cnt)
    );

    // Blanking looks at the count the slot is about to hold, so the
    // registered anodes line up with the cycles the prescaler is in.
    assign cnt_next = tick ? '0 : cnt + CNT_W'(1);

    assign wrap = tick && (digit == digit_t'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (tick) begin
            digit <= digit + 2'd1;
        end
    end

    // The commit on a wrap always takes the shadow as it was before this
    // edge; a load landing on the same edge stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (wrap && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        blank = 1'b0;
        if (32'(cnt_next) < BLANK_LIM) begin
            blank = 1'b1;
        end
        if (lz_en && upper_zero(active, digit)) begin
            blank = 1'b1;
        end
    end

    // num keeps carrying the nibble during blanking; only the anodes go off.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw         <= '0;
            num        <= '0;
            an_n       <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            sw         <= digit;
            num        <= active[{digit, 2'b00} +: 4];
            an_n       <= blank ? AN_OFF : AN_CODE[digit];
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb/tb_sevseg_scan_ctrl.sv - scoreboard bench for sevseg_scan_ctrl

module tb_sevseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [1:0]  sw;
    logic [3:0]  num;
    logic [3:0]  an_n;
    logic        frame_done;

    logic [1:0]  sw2;
    logic [3:0]  num2;
    logic [3:0]  an2;
    logic        fd2;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    typedef struct packed {
        logic [1:0] sw;
        logic [3:0] num;
        logic [3:0] an_n;
        logic [3:0] prev_an;
        logic       prev_fd;
    } slot_t;

    slot_t exp_q[$];

    always #5 clk = ~clk;

    sevseg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .lz_en      (lz_en),
        .sw         (sw),
        .num        (num),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    sevseg_scan_ctrl #(.REFRESH_DIV(1), .BLANK_CYC(0)) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .value_in   (16'h0000),
        .load       (1'b0),
        .lz_en      (1'b0),
        .sw         (sw2),
        .num        (num2),
        .an_n       (an2),
        .frame_done (fd2)
    );

    function automatic logic [3:0] an_code(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // One frame of expected slots: lit[d]=1 means digit d should be driven.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] lit);
        slot_t e;
        for (int i = 0; i < 4; i++) begin
            e.sw      = 2'(i);
            e.num     = v[4*i +: 4];
            e.an_n    = lit[i] ? an_code(i) : 4'hF;
            e.prev_an = 4'hF;
            e.prev_fd = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic frame_boundary();
        int n     = 0;
        bit found = 1'b0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_done_timeout waited=%0d required=pulse within 40 cycles", n);
        end else begin
            armed = 1'b1;
        end
    endtask

    // Monitor: a slot starts when sw changes; compare against the scoreboard.
    initial begin
        logic [1:0] prev_sw;
        logic [3:0] prev_an;
        logic       prev_fd;
        slot_t      got;
        slot_t      e;
        prev_sw = 2'd0;
        prev_an = 4'hF;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sw = 2'd0;
                prev_an = 4'hF;
                prev_fd = 1'b0;
            end else begin
                if (armed && sw != prev_sw) begin
                    got = '{sw: sw, num: num, an_n: an_n, prev_an: prev_an, prev_fd: prev_fd};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_slot got sw=%0d num=%h an_n=%b required=no slot", sw, num, an_n);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            failures++;
                            $display("FAIL slot got sw=%0d num=%h an_n=%b prev_an=%b prev_fd=%b required sw=%0d num=%h an_n=%b prev_an=%b prev_fd=%b",
                                     got.sw, got.num, got.an_n, got.prev_an, got.prev_fd,
                                     e.sw, e.num, e.an_n, e.prev_an, e.prev_fd);
                        end
                    end
                end
                prev_sw = sw;
                prev_an = an_n;
                prev_fd = frame_done;
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        load     = 1'b0;
        lz_en    = 1'b0;
        value_in = 16'h0000;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check("reset_an_n", 32'(an_n), 32'hF);
            check("reset_sw", 32'(sw), 32'h0);
            check("reset_num", 32'(num), 32'h0);
            check("reset_frame_done", 32'(frame_done), 32'h0);
        end
        rst = 1'b0;

        // REFRESH_DIV=1 instance: sw steps every cycle, frame_done every 4th
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("div1_sw", 32'(sw2), 32'((k - 1) % 4));
            check("div1_frame_done", 32'(fd2), 32'(((k - 1) % 4) == 3));
            check("div1_an_n", 32'(an2), 32'(an_code((k - 1) % 4)));
        end

        // Value 0 scanning, then a mid-frame load of 1A3F
        frame_boundary();
        push_frame(16'h0000, 4'b1111);
        frame_boundary();
        push_frame(16'h0000, 4'b1111);
        idle(6);
        pulse_load(16'h1A3F);
        frame_boundary();
        push_frame(16'h1A3F, 4'b1111);

        // Leading-zero suppression
        lz_en = 1'b1;
        idle(5);
        pulse_load(16'h0005);
        frame_boundary();
        push_frame(16'h0005, 4'b0001);
        idle(5);
        pulse_load(16'h0000);
        frame_boundary();
        push_frame(16'h0000, 4'b0001);
        idle(5);
        pulse_load(16'h0100);
        frame_boundary();
        push_frame(16'h0100, 4'b0111);

        // Last load wins; load on the exact wrap edge waits a frame
        frame_boundary();
        lz_en = 1'b0;
        push_frame(16'h0100, 4'b1111);
        idle(2);
        pulse_load(16'h1111);
        idle(4);
        pulse_load(16'h2222);
        idle(7);
        value_in = 16'h3333;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        check("wrap_load_frame_done", 32'(frame_done), 32'h1);
        push_frame(16'h2222, 4'b1111);
        frame_boundary();
        push_frame(16'h3333, 4'b1111);
        frame_boundary();
        push_frame(16'h3333, 4'b1111);

        // Reset mid-frame with a load pending
        frame_boundary();
        armed = 1'b0;
        pulse_load(16'h4444);
        n = 0;
        while (sw != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sw2_reached", 32'(sw), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_sw", 32'(sw), 32'h0);
        check("midreset_num", 32'(num), 32'h0);
        check("midreset_an_n", 32'(an_n), 32'hF);
        check("midreset_frame_done", 32'(frame_done), 32'h0);
        frame_boundary();
        push_frame(16'h0000, 4'b1111);
        frame_boundary();
        push_frame(16'h0000, 4'b1111);
        idle(16);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=time %0t required=finish earlier", $time);
        $fatal(1);
    end

endmodule
